// File: rtl/video_pkg.sv
// Shared video definitions: display mode encodings, key debounce states and
// the mode-advance helper used by display_mode_ctrl and video_display.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_BAR   = 2'd0,
        MODE_BLOCK = 2'd1,
        MODE_WHITE = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        DEB_IDLE         = 2'd0,
        DEB_PRESS_WAIT   = 2'd1,
        DEB_HELD         = 2'd2,
        DEB_RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Wraps to mode 0 once the last configured mode has been shown.
    function automatic logic [1:0] next_mode(input logic [1:0] cur,
                                             input logic [1:0] num_modes);
        return (cur >= num_modes - 2'd1) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM for an active-low
// push-button; emits a single-cycle press pulse per debounced press.
module key_debounce
    import video_pkg::*;
#(
    parameter logic [21:0] DEB_CYCLES = 22'd1500000
)(
    input  logic pixel_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press
);

    logic [1:0]  sync_q;
    logic        key_low;
    deb_state_t  state, state_next;
    logic [21:0] cnt, cnt_next;
    logic        cnt_done;

    // Synchroniser idles high so reset looks like a released key.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign key_low  = ~sync_q[1];
    assign cnt_done = (cnt == DEB_CYCLES - 22'd1);

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= DEB_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Any bounce during a wait state drops back and clears the counter.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        press      = 1'b0;
        case (state)
            DEB_IDLE: begin
                if (key_low) state_next = DEB_PRESS_WAIT;
            end
            DEB_PRESS_WAIT: begin
                if (!key_low) begin
                    state_next = DEB_IDLE;
                end else if (cnt_done) begin
                    state_next = DEB_HELD;
                    press      = 1'b1;
                end else begin
                    cnt_next = cnt + 22'd1;
                end
            end
            DEB_HELD: begin
                if (!key_low) state_next = DEB_RELEASE_WAIT;
            end
            DEB_RELEASE_WAIT: begin
                if (key_low) begin
                    state_next = DEB_HELD;
                end else if (cnt_done) begin
                    state_next = DEB_IDLE;
                end else begin
                    cnt_next = cnt + 22'd1;
                end
            end
            default: state_next = DEB_IDLE;
        endcase
    end

endmodule

// File: rtl/display_mode_ctrl.sv
// Frame-locked display mode controller: key presses (and, with
// MODE_AUTO_CYCLE_EN defined, a frame counter) step disp_mode at frame start.
module display_mode_ctrl
    import video_pkg::*;
#(
    parameter logic [10:0] H_DISP      = 11'd1280,
    parameter logic [10:0] V_DISP      = 11'd720,
    parameter logic [21:0] DEB_CYCLES  = 22'd1500000,
    parameter logic [9:0]  AUTO_FRAMES = 10'd300,
    parameter logic [1:0]  NUM_MODES   = 2'd3
)(
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic        key_n,
    output logic [1:0]  disp_mode,
    output logic        frame_start,
    output logic        move_en,
    output logic        mode_chg
);

    logic press_evt;
    logic at_origin;
    logic prev_at_origin;
    logic pending;
    logic auto_hit;
    logic step;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_n),
        .press     (press_evt)
    );

    // Raster size is informational; frame timing comes from the driver's coordinates.
    logic unused_geom;
    assign unused_geom = ^{H_DISP, V_DISP};

    assign at_origin = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    assign step      = frame_start && (pending || auto_hit);

`ifdef MODE_AUTO_CYCLE_EN
    logic [9:0] auto_cnt;

    assign auto_hit = frame_start && (auto_cnt == AUTO_FRAMES - 10'd1);

    // Any applied step, key or automatic, restarts the frame count.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            auto_cnt <= '0;
        end else if (step) begin
            auto_cnt <= '0;
        end else if (frame_start) begin
            auto_cnt <= auto_cnt + 10'd1;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = ^AUTO_FRAMES;
    assign auto_hit    = 1'b0;
`endif

    // Mode only moves on the cycle after frame_start; move_en uses the pre-update mode.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_at_origin <= 1'b0;
            frame_start    <= 1'b0;
            move_en        <= 1'b0;
            mode_chg       <= 1'b0;
            disp_mode      <= MODE_BAR;
            pending        <= 1'b0;
        end else begin
            prev_at_origin <= at_origin;
            frame_start    <= at_origin && !prev_at_origin;
            move_en        <= frame_start && (disp_mode == MODE_BLOCK);
            mode_chg       <= step;
            if (step) begin
                disp_mode <= next_mode(disp_mode, NUM_MODES);
            end
            if (press_evt) begin
                pending <= 1'b1;
            end else if (step) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 SHALL have parameter H_DISP, default 11'd1280, active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 11'd720, active lines per frame.
REQ-003 SHALL have parameter DEB_CYCLES, default 22'd1500000, key debounce time in pixel clocks (20 ms at 75 MHz).
REQ-004 SHALL have parameter AUTO_FRAMES, default 10'd300, frames per automatic mode step.
REQ-005 SHALL have parameter NUM_MODES, default 2'd3, number of display modes (0 = colour bar, 1 = bouncing block, 2 = solid white).
REQ-006 SHALL have port pixel_clk  input  1  pixel clock (75 MHz), the only clock.
REQ-007 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port pixel_xpos  input  11  current pixel x coordinate from the HDMI driver.
REQ-009 SHALL have port pixel_ypos  input  11  current pixel y coordinate from the HDMI driver.
REQ-010 SHALL have port key_n  input  1  raw push-button, active-low, asynchronous to pixel_clk.
REQ-011 SHALL have port disp_mode  output  2  mode the pattern generator draws this frame.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse at the start of each frame.
REQ-013 SHALL have port move_en  output  1  one-cycle pulse per frame while disp_mode = 1, frame-locked replacement for the free-running 100 Hz divider.
REQ-014 SHALL have port mode_chg  output  1  one-cycle pulse on the cycle disp_mode changes.

Function
REQ-015 SHALL synchronise key_n through two flops before any other use.
REQ-016 SHALL debounce with FSM IDLE -> PRESS_WAIT (sync key low) -> HELD (low for DEB_CYCLES consecutive cycles) -> RELEASE_WAIT (sync key high) -> IDLE (high for DEB_CYCLES consecutive cycles).
REQ-017 SHALL return PRESS_WAIT to IDLE and RELEASE_WAIT to HELD when the key bounces, clearing the debounce counter.
REQ-018 SHALL generate one press event per PRESS_WAIT -> HELD transition; holding the key yields no further events.
REQ-019 SHALL assert frame_start for one cycle on the cycle after (pixel_xpos, pixel_ypos) becomes (0,0) having been non-(0,0) on the previous cycle.
REQ-020 SHALL set a pending flag on a press event and hold it until the next frame_start.
REQ-021 SHALL update disp_mode only on the cycle after frame_start, never mid-frame.
REQ-022 SHALL advance disp_mode by exactly one when pending, wrapping from NUM_MODES-1 to 0, and clear pending on that cycle.
REQ-023 SHALL step once only when a press and an auto step fall in the same frame.
REQ-024 SHALL set pending again when a new press event coincides with the apply cycle, so the press is applied one frame later.
REQ-025 SHALL pulse mode_chg together with the disp_mode update.
REQ-026 SHALL pulse move_en on the cycle after frame_start whenever disp_mode = 1, using the mode value held before any update on that cycle.

Reset
REQ-027 SHALL on sys_rst_n low immediately force disp_mode = 0, frame_start = 0, move_en = 0, mode_chg = 0, pending = 0, debounce FSM = IDLE, all counters = 0, synchroniser flops = 1.
REQ-028 SHALL treat reset asserted mid-debounce or mid-frame as a full restart; the first frame_start after release is the first (0,0) entry seen.

Configuration
REQ-029 SHALL, with MODE_AUTO_CYCLE_EN defined, count frame_start pulses and set pending at the AUTO_FRAMES-th pulse, then restart the count.
REQ-030 SHALL restart the auto count on every applied mode change, including key-driven changes.
REQ-031 SHALL, without MODE_AUTO_CYCLE_EN, omit the auto counter so the mode changes only on key presses.

Structure
REQ-032 SHALL place mode encodings (MODE_BAR, MODE_BLOCK, MODE_WHITE) and debounce state encodings in shared package video_pkg, reused by video_display.
REQ-033 SHALL implement the synchroniser and debounce FSM as sub-module key_debounce, outputting a one-cycle press pulse.

Verification
REQ-034 SHALL cover this case: DEB_CYCLES=16; key_n low for 20 cycles, then high -> exactly one press pulse; disp_mode 0->1 one cycle after the next frame_start, with mode_chg pulsed.
REQ-035 SHALL cover this case: key_n toggling every 5 cycles for 100 cycles (DEB_CYCLES=16) -> no press pulse, disp_mode unchanged.
REQ-036 SHALL cover this case: three debounced presses in separate frames from mode 0 -> disp_mode sequence 1, 2, 0.
REQ-037 SHALL cover this case: disp_mode=1 over 4 frames -> exactly 4 move_en pulses, each one cycle after frame_start; disp_mode=0 -> none.
REQ-038 SHALL cover this case: MODE_AUTO_CYCLE_EN, AUTO_FRAMES=3, a press landing in frame 3 -> a single step, after which the next auto step follows 3 frames later.
REQ-039 SHALL cover this case: sys_rst_n low for 1 cycle during HELD with disp_mode=2 -> outputs 0 immediately, and a release then re-press yields a normal single step to mode 1.
